// File: rtl/data_mem_be.sv
// Single-port word memory with per-byte write enables, registered write-first read,
// and a reset-triggered sequencer that zeroes one word per cycle.
module data_mem_be #(
  parameter  int DATA_W = 32,
  parameter  int ADDR_W = 6,
  localparam int NBYTES = DATA_W / 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              read_enable,
  input  logic              write_enable,
  input  logic [ADDR_W-1:0] a,
  input  logic [DATA_W-1:0] d,
  input  logic [NBYTES-1:0] be,
  output logic [DATA_W-1:0] q,
  output logic              q_valid,
  output logic              busy,
  output logic              req_err
);

  localparam int              DEPTH     = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  typedef enum logic {ST_CLEAR, ST_READY} state_t;

  state_t              state_q;
  logic [ADDR_W-1:0]   clr_ptr_q;
  logic [DATA_W-1:0]   q_q;
  logic                q_valid_q;
  logic                busy_q;
  logic                req_err_q;

  logic [DATA_W-1:0]   mem [DEPTH];
  logic [DATA_W-1:0]   mem_rd;
  logic [NBYTES-1:0]   wr_lanes;
  logic [DATA_W-1:0]   merged_d;

  function automatic logic [DATA_W-1:0] merge_bytes(
    input logic [DATA_W-1:0] old_w,
    input logic [DATA_W-1:0] new_w,
    input logic [NBYTES-1:0] lane_en
  );
    logic [DATA_W-1:0] res;
    res = old_w;
    for (int i = 0; i < NBYTES; i++) begin
      if (lane_en[i]) res[8*i +: 8] = new_w[8*i +: 8];
    end
    return res;
  endfunction

  // The merged word serves both the array update and the write-first read return.
  always_comb begin
    mem_rd   = mem[a];
    wr_lanes = write_enable ? be : '0;
    merged_d = merge_bytes(mem_rd, d, wr_lanes);
  end

  // Array storage: no reset, cleared word by word by the sequencer instead.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state_q == ST_CLEAR) begin
        mem[clr_ptr_q] <= '0;
      end else if (write_enable) begin
        mem[a] <= merged_d;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_CLEAR;
      clr_ptr_q <= '0;
      busy_q    <= 1'b1;
      q_q       <= '0;
      q_valid_q <= 1'b0;
      req_err_q <= 1'b0;
    end else begin
      case (state_q)
        ST_CLEAR: begin
          q_q       <= '0;
          q_valid_q <= 1'b0;
          req_err_q <= read_enable | write_enable;
          clr_ptr_q <= clr_ptr_q + ADDR_W'(1);
          if (clr_ptr_q == LAST_ADDR) begin
            state_q <= ST_READY;
            busy_q  <= 1'b0;
          end
        end
        default: begin
          busy_q    <= 1'b0;
          req_err_q <= 1'b0;
          q_valid_q <= read_enable;
          q_q       <= read_enable ? merged_d : '0;
        end
      endcase
    end
  end

  assign q       = q_q;
  assign q_valid = q_valid_q;
  assign busy    = busy_q;
  assign req_err = req_err_q;

endmodule

// File: tb/tb_data_mem_be.sv
// Directed bench for data_mem_be: clear sequence, byte enables, write-first,
// requests while busy, reset mid-clear and read gaps.
module tb_data_mem_be;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 6;
  localparam int NBYTES = DATA_W / 8;

  logic              clk;
  logic              rst;
  logic              read_enable;
  logic              write_enable;
  logic [ADDR_W-1:0] a;
  logic [DATA_W-1:0] d;
  logic [NBYTES-1:0] be;
  logic [DATA_W-1:0] q;
  logic              q_valid;
  logic              busy;
  logic              req_err;

  int errors;
  int checks;

  data_mem_be #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst), .read_enable(read_enable), .write_enable(write_enable),
    .a(a), .d(d), .be(be), .q(q), .q_valid(q_valid), .busy(busy), .req_err(req_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one edge; outputs are then sampled 1ns after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] data,
                          input logic [NBYTES-1:0] lanes);
    write_enable = 1'b1; a = addr; d = data; be = lanes;
    step();
    write_enable = 1'b0; be = '0;
  endtask

  // Counts cycles with busy high starting from the rst edge; bounded.
  task automatic count_busy(output int cnt);
    cnt = 1;
    for (int i = 0; i < 200; i++) begin
      step();
      if (busy) cnt++;
      else break;
    end
  endtask

  task automatic test_reset();
    int cnt;
    rst = 1'b1;
    step();
    checks++;
    if (busy !== 1'b1 || q !== 32'h0 || q_valid !== 1'b0 || req_err !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: busy=%b q=%h q_valid=%b req_err=%b, want busy=1 q=0 q_valid=0 req_err=0",
               busy, q, q_valid, req_err);
    end
    rst = 1'b0;
    count_busy(cnt);
    checks++;
    if (cnt !== 64) begin
      errors++;
      $display("FAIL clear_busy_len: got %0d cycles, want 64", cnt);
    end
  endtask

  task automatic test_clear_readback();
    for (int i = 0; i < 64; i++) begin
      read_enable = 1'b1; a = ADDR_W'(i);
      step();
      checks++;
      if (q !== 32'h0 || q_valid !== 1'b1) begin
        errors++;
        $display("FAIL clear_read[%0d]: q=%h q_valid=%b, want q=00000000 q_valid=1", i, q, q_valid);
      end
    end
    read_enable = 1'b0;
    step();
  endtask

  task automatic test_byte_enable();
    do_write(6'd5, 32'hAABBCCDD, 4'b1111);
    do_write(6'd5, 32'h11223344, 4'b0101);
    do_write(6'd5, 32'h00000000, 4'b0000);
    read_enable = 1'b1; a = 6'd5;
    step();
    read_enable = 1'b0;
    checks++;
    if (q !== 32'hAA22CC44 || q_valid !== 1'b1) begin
      errors++;
      $display("FAIL byte_enable: q=%h q_valid=%b, want q=aa22cc44 q_valid=1", q, q_valid);
    end
  endtask

  task automatic test_write_first();
    do_write(6'd9, 32'h01020304, 4'b1111);
    read_enable = 1'b1; write_enable = 1'b1; a = 6'd9; d = 32'hFFFFFFFF; be = 4'b1000;
    step();
    write_enable = 1'b0; be = '0;
    checks++;
    if (q !== 32'hFF020304 || q_valid !== 1'b1) begin
      errors++;
      $display("FAIL write_first_q: q=%h q_valid=%b, want q=ff020304 q_valid=1", q, q_valid);
    end
    a = 6'd9;
    step();
    read_enable = 1'b0;
    checks++;
    if (q !== 32'hFF020304) begin
      errors++;
      $display("FAIL write_first_array: q=%h, want ff020304", q);
    end
  endtask

  task automatic test_back_to_back();
    read_enable = 1'b1; a = 6'd5;
    step();
    a = 6'd9;
    checks++;
    if (q !== 32'hAA22CC44 || q_valid !== 1'b1) begin
      errors++;
      $display("FAIL b2b_first: q=%h q_valid=%b, want q=aa22cc44 q_valid=1", q, q_valid);
    end
    step();
    read_enable = 1'b0;
    checks++;
    if (q !== 32'hFF020304 || q_valid !== 1'b1) begin
      errors++;
      $display("FAIL b2b_second: q=%h q_valid=%b, want q=ff020304 q_valid=1", q, q_valid);
    end
  endtask

  task automatic test_busy_access();
    int cnt;
    do_write(6'd3, 32'hCAFE0003, 4'b1111);
    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int i = 0; i < 9; i++) step();
    write_enable = 1'b1; a = 6'd3; d = 32'h12345678; be = 4'b1111;
    step();
    write_enable = 1'b0; be = '0;
    checks++;
    if (req_err !== 1'b1 || busy !== 1'b1 || q_valid !== 1'b0) begin
      errors++;
      $display("FAIL busy_req_err: req_err=%b busy=%b q_valid=%b, want 1 1 0", req_err, busy, q_valid);
    end
    step();
    checks++;
    if (req_err !== 1'b0) begin
      errors++;
      $display("FAIL busy_req_err_pulse: req_err=%b, want 0", req_err);
    end
    count_busy(cnt);
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL busy_timeout: busy=%b, want 0", busy);
    end
    read_enable = 1'b1; a = 6'd3;
    step();
    read_enable = 1'b0;
    checks++;
    if (q !== 32'h0 || q_valid !== 1'b1) begin
      errors++;
      $display("FAIL busy_write_ignored: q=%h q_valid=%b, want q=00000000 q_valid=1", q, q_valid);
    end
  endtask

  task automatic test_reset_mid_clear();
    int cnt;
    do_write(6'd63, 32'hDEADBEEF, 4'b1111);
    read_enable = 1'b1; a = 6'd63;
    step();
    read_enable = 1'b0;
    checks++;
    if (q !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL pre_reset_word63: q=%h, want deadbeef", q);
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int i = 0; i < 20; i++) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    count_busy(cnt);
    checks++;
    if (cnt !== 64) begin
      errors++;
      $display("FAIL restart_busy_len: got %0d cycles, want 64", cnt);
    end
    read_enable = 1'b1; a = 6'd63;
    step();
    read_enable = 1'b0;
    checks++;
    if (q !== 32'h0 || q_valid !== 1'b1) begin
      errors++;
      $display("FAIL restart_word63: q=%h q_valid=%b, want q=00000000 q_valid=1", q, q_valid);
    end
  endtask

  task automatic test_read_gap();
    do_write(6'd2, 32'hCAFEF00D, 4'b1111);
    read_enable = 1'b1; a = 6'd2;
    step();
    read_enable = 1'b0;
    checks++;
    if (q !== 32'hCAFEF00D || q_valid !== 1'b1) begin
      errors++;
      $display("FAIL gap_read: q=%h q_valid=%b, want q=cafef00d q_valid=1", q, q_valid);
    end
    step();
    checks++;
    if (q !== 32'h0 || q_valid !== 1'b0) begin
      errors++;
      $display("FAIL gap_idle: q=%h q_valid=%b, want q=00000000 q_valid=0", q, q_valid);
    end
  endtask

  initial begin
    errors = 0; checks = 0;
    rst = 1'b0; read_enable = 1'b0; write_enable = 1'b0;
    a = '0; d = '0; be = '0;
    #2;
    test_reset();
    test_clear_readback();
    test_byte_enable();
    test_write_first();
    test_back_to_back();
    test_busy_access();
    test_reset_mid_clear();
    test_read_gap();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
